// File: rtl/array_heap.sv
// Pool of fixed-size arrays with alloc/free, push/pop, element arithmetic and scans.
// Requests use a valid/ready handshake; each one produces a single resp_valid pulse.
module array_heap #(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned INDEX_BITS   = 3,
  parameter int unsigned DATA_BITS    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              action,
  input  logic [ADDRESS_BITS-1:0] array,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_BITS-1:0]    in,
  output logic                    resp_valid,
  output logic [DATA_BITS-1:0]    out,
  output logic [ADDRESS_BITS-1:0] alloc_array,
  output logic [31:0]             error
);
  localparam int unsigned ARRAYS       = 2 ** ADDRESS_BITS;
  localparam int unsigned ARRAY_LENGTH = 2 ** INDEX_BITS;
  localparam int unsigned ELEMS        = ARRAYS * ARRAY_LENGTH;
  localparam int unsigned SIZE_BITS    = INDEX_BITS + 1;
  localparam int unsigned CNT_BITS     = ADDRESS_BITS + 1;

  localparam logic [7:0] ActReset    = 8'd1;
  localparam logic [7:0] ActWrite    = 8'd2;
  localparam logic [7:0] ActRead     = 8'd3;
  localparam logic [7:0] ActSize     = 8'd4;
  localparam logic [7:0] ActInc      = 8'd5;
  localparam logic [7:0] ActDec      = 8'd6;
  localparam logic [7:0] ActIndex    = 8'd7;
  localparam logic [7:0] ActLess     = 8'd8;
  localparam logic [7:0] ActGreater  = 8'd9;
  localparam logic [7:0] ActPush     = 8'd14;
  localparam logic [7:0] ActPop      = 8'd15;
  localparam logic [7:0] ActResize   = 8'd17;
  localparam logic [7:0] ActAlloc    = 8'd18;
  localparam logic [7:0] ActFree     = 8'd19;
  localparam logic [7:0] ActAdd      = 8'd20;
  localparam logic [7:0] ActSubtract = 8'd22;

  localparam logic [31:0] ErrNone      = 32'd0;
  localparam logic [31:0] ErrNotAlloc  = 32'd1;
  localparam logic [31:0] ErrRange     = 32'd2;
  localparam logic [31:0] ErrOverflow  = 32'd3;
  localparam logic [31:0] ErrUnderflow = 32'd4;
  localparam logic [31:0] ErrDblFree   = 32'd5;
  localparam logic [31:0] ErrExhausted = 32'd6;
  localparam logic [31:0] ErrUnknown   = 32'd7;

  typedef enum logic [1:0] {StIdle, StExec, StScan} state_e;

  state_e state_q, state_d;

  logic [7:0]              action_q;
  logic [ADDRESS_BITS-1:0] array_q;
  logic [INDEX_BITS-1:0]   index_q;
  logic [DATA_BITS-1:0]    in_q;

  logic [DATA_BITS-1:0]    mem [ELEMS];
  logic [SIZE_BITS-1:0]    size_q [ARRAYS];
  logic [ARRAYS-1:0]       allocated_q;
  logic [ADDRESS_BITS-1:0] stack_q [ARRAYS];
  logic [CNT_BITS-1:0]     top_q;
  logic [CNT_BITS-1:0]     fresh_q;

  logic [INDEX_BITS-1:0]   scan_idx_q;
  logic [SIZE_BITS-1:0]    scan_cnt_q;

  logic [DATA_BITS-1:0]    out_q;
  logic [31:0]             error_q;
  logic [ADDRESS_BITS-1:0] alloc_array_q;

  logic                    accept;
  logic                    exec_fire;
  logic [SIZE_BITS-1:0]    cur_size;
  logic                    cur_alloc;
  logic [INDEX_BITS-1:0]   rd_idx;
  logic [DATA_BITS-1:0]    rd_elem;

  logic                    scan_in_range;
  logic                    scan_last;
  logic                    scan_hit;
  logic                    scan_done;
  logic [DATA_BITS-1:0]    scan_out;

  logic [31:0]             ex_err;
  logic [DATA_BITS-1:0]    ex_out;
  logic                    mem_we;
  logic [INDEX_BITS-1:0]   mem_widx;
  logic [DATA_BITS-1:0]    mem_wdata;
  logic                    size_we;
  logic [ADDRESS_BITS-1:0] size_waddr;
  logic [SIZE_BITS-1:0]    size_wdata;
  logic                    set_alloc;
  logic                    clr_alloc;
  logic [ADDRESS_BITS-1:0] alloc_sel;
  logic                    stack_push;
  logic                    stack_pop;
  logic                    fresh_inc;
  logic                    clear_all;

  logic [DATA_BITS-1:0]    rsp_out;
  logic [31:0]             rsp_err;
  logic                    rsp_alloc;

  function automatic logic is_scan(logic [7:0] a);
    return (a == ActIndex) || (a == ActLess) || (a == ActGreater);
  endfunction

  function automatic logic is_array_op(logic [7:0] a);
    case (a)
      ActWrite, ActRead, ActSize, ActInc, ActDec, ActIndex, ActLess, ActGreater,
      ActPush, ActPop, ActResize, ActAdd, ActSubtract: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign accept    = req_valid && (state_q == StIdle) && !reset;
  assign exec_fire = (state_q == StExec) && !reset;
  assign cur_size  = size_q[array_q];
  assign cur_alloc = allocated_q[array_q];

  // Single read port shared by scans, Pop and indexed element access.
  always_comb begin
    if (state_q == StScan) begin
      rd_idx = scan_idx_q;
    end else if (action_q == ActPop) begin
      rd_idx = cur_size[INDEX_BITS-1:0] - INDEX_BITS'(1);
    end else begin
      rd_idx = index_q;
    end
  end
  assign rd_elem = mem[{array_q, rd_idx}];

  always_comb begin
    scan_in_range = SIZE_BITS'(scan_idx_q) < cur_size;
    scan_last     = (SIZE_BITS'(scan_idx_q) + SIZE_BITS'(1)) >= cur_size;
    scan_hit      = 1'b0;
    case (action_q)
      ActIndex:   scan_hit = (rd_elem == in_q);
      ActLess:    scan_hit = (rd_elem < in_q);
      ActGreater: scan_hit = (rd_elem > in_q);
      default:    scan_hit = 1'b0;
    endcase
    scan_hit  = scan_hit && scan_in_range;
    scan_done = scan_last || ((action_q == ActIndex) && scan_hit);
    if (action_q == ActIndex) begin
      scan_out = scan_hit ? DATA_BITS'(scan_idx_q) + DATA_BITS'(1) : '0;
    end else begin
      scan_out = DATA_BITS'(scan_cnt_q + SIZE_BITS'(scan_hit));
    end
  end

  // Single-cycle actions; every enable is raised only on the success path.
  always_comb begin
    ex_err     = ErrNone;
    ex_out     = '0;
    mem_we     = 1'b0;
    mem_widx   = index_q;
    mem_wdata  = in_q;
    size_we    = 1'b0;
    size_waddr = array_q;
    size_wdata = cur_size;
    set_alloc  = 1'b0;
    clr_alloc  = 1'b0;
    alloc_sel  = '0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    fresh_inc  = 1'b0;
    clear_all  = 1'b0;
    if (action_q == ActReset) begin
      clear_all = 1'b1;
    end else if (action_q == ActAlloc) begin
      if (top_q != '0) begin
        alloc_sel = stack_q[top_q[ADDRESS_BITS-1:0] - ADDRESS_BITS'(1)];
        stack_pop = 1'b1;
      end else if (fresh_q != CNT_BITS'(ARRAYS)) begin
        alloc_sel = fresh_q[ADDRESS_BITS-1:0];
        fresh_inc = 1'b1;
      end else begin
        ex_err = ErrExhausted;
      end
      if (ex_err == ErrNone) begin
        set_alloc  = 1'b1;
        size_we    = 1'b1;
        size_waddr = alloc_sel;
        size_wdata = '0;
        ex_out     = DATA_BITS'(alloc_sel);
      end
    end else if (action_q == ActFree) begin
      if (!cur_alloc) begin
        ex_err = ErrDblFree;
      end else begin
        clr_alloc  = 1'b1;
        stack_push = 1'b1;
      end
    end else if (!is_array_op(action_q)) begin
      ex_err = ErrUnknown;
    end else if (!cur_alloc) begin
      ex_err = ErrNotAlloc;
    end else begin
      case (action_q)
        ActWrite, ActRead, ActAdd, ActSubtract: begin
          if (SIZE_BITS'(index_q) >= cur_size) begin
            ex_err = ErrRange;
          end else if (action_q == ActRead) begin
            ex_out = rd_elem;
          end else begin
            if (action_q == ActAdd) begin
              mem_wdata = rd_elem + in_q;
            end else if (action_q == ActSubtract) begin
              mem_wdata = rd_elem - in_q;
            end
            mem_we = 1'b1;
            ex_out = (action_q == ActWrite) ? '0 : mem_wdata;
          end
        end
        ActSize: ex_out = DATA_BITS'(cur_size);
        ActInc, ActDec: begin
          size_we = 1'b1;
          if (action_q == ActInc && cur_size != SIZE_BITS'(ARRAY_LENGTH)) begin
            size_wdata = cur_size + SIZE_BITS'(1);
          end else if (action_q == ActDec && cur_size != '0) begin
            size_wdata = cur_size - SIZE_BITS'(1);
          end
          ex_out = DATA_BITS'(size_wdata);
        end
        ActPush: begin
          if (cur_size == SIZE_BITS'(ARRAY_LENGTH)) begin
            ex_err = ErrOverflow;
          end else begin
            mem_we     = 1'b1;
            mem_widx   = cur_size[INDEX_BITS-1:0];
            size_we    = 1'b1;
            size_wdata = cur_size + SIZE_BITS'(1);
            ex_out     = DATA_BITS'(size_wdata);
          end
        end
        ActPop: begin
          if (cur_size == '0) begin
            ex_err = ErrUnderflow;
          end else begin
            size_we    = 1'b1;
            size_wdata = cur_size - SIZE_BITS'(1);
            ex_out     = rd_elem;
          end
        end
        ActResize: begin
          if (in_q > DATA_BITS'(ARRAY_LENGTH)) begin
            ex_err = ErrRange;
          end else begin
            size_we    = 1'b1;
            size_wdata = in_q[SIZE_BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (is_scan(action) && allocated_q[array]) ? StScan : StExec;
        end
      end
      StExec:  state_d = StIdle;
      StScan:  if (scan_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; the response is presented in the final EXEC/SCAN cycle, then held.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = !reset && ((state_q == StExec) || ((state_q == StScan) && scan_done));
    rsp_out    = (state_q == StScan) ? scan_out : ex_out;
    rsp_err    = (state_q == StScan) ? ErrNone : ex_err;
    rsp_alloc  = (state_q == StExec) && set_alloc;
    out        = resp_valid ? rsp_out : out_q;
    error      = resp_valid ? rsp_err : error_q;
    alloc_array = (resp_valid && rsp_alloc) ? alloc_sel : alloc_array_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q         <= '0;
      error_q       <= '0;
      alloc_array_q <= '0;
    end else if (resp_valid) begin
      out_q   <= rsp_out;
      error_q <= rsp_err;
      if (rsp_alloc) alloc_array_q <= alloc_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      action_q   <= action;
      array_q    <= array;
      index_q    <= index;
      in_q       <= in;
      scan_idx_q <= '0;
      scan_cnt_q <= '0;
    end else if (state_q == StScan) begin
      scan_idx_q <= scan_idx_q + INDEX_BITS'(1);
      scan_cnt_q <= scan_cnt_q + SIZE_BITS'(scan_hit);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (exec_fire && clear_all)) begin
      allocated_q <= '0;
      top_q       <= '0;
      fresh_q     <= '0;
      for (int i = 0; i < ARRAYS; i++) size_q[i] <= '0;
    end else if (exec_fire) begin
      if (size_we) size_q[size_waddr] <= size_wdata;
      if (set_alloc) allocated_q[alloc_sel] <= 1'b1;
      if (clr_alloc) allocated_q[array_q] <= 1'b0;
      if (stack_push) top_q <= top_q + CNT_BITS'(1);
      if (stack_pop) top_q <= top_q - CNT_BITS'(1);
      if (fresh_inc) fresh_q <= fresh_q + CNT_BITS'(1);
    end
  end

  // Element contents and the free stack body survive reset.
  always_ff @(posedge clock) begin
    if (exec_fire && mem_we) mem[{array_q, mem_widx}] <= mem_wdata;
    if (exec_fire && stack_push) stack_q[top_q[ADDRESS_BITS-1:0]] <= array_q;
  end

endmodule
